// File: rtl/wb_pkg.sv
// Shared definitions for the writeback unit: register address width,
// default data width and the queued-entry payload.
package wb_pkg;

  localparam int unsigned REG_ADDR_W   = 5;
  localparam int unsigned XLEN_DEFAULT = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0]   rd;
    logic [XLEN_DEFAULT-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order write queue with two ordered push ports (a before b) and one pop.
// Every slot and its valid bit is exposed so the parent can build the
// pending scoreboard and the forwarding lookup.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   push_a/rd_a/data_a    first push (older of the two when both fire)
//   push_b/rd_b/data_b    second push
//   pop                   drop the head entry
//   count                 occupancy, 0..DEPTH
//   rd_ptr                head slot index
//   entry_rd/entry_data   flattened slot contents, slot i at [i*W +: W]
//   entry_valid           per-slot occupied flag
// The parent guarantees pushes never exceed free space and pop only when
// count != 0.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = XLEN_DEFAULT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push_a,
  input  logic [REG_ADDR_W-1:0]         rd_a,
  input  logic [XLEN-1:0]               data_a,
  input  logic                          push_b,
  input  logic [REG_ADDR_W-1:0]         rd_b,
  input  logic [XLEN-1:0]               data_b,
  input  logic                          pop,
  output logic [$clog2(DEPTH):0]        count,
  output logic [$clog2(DEPTH)-1:0]      rd_ptr,
  output logic [DEPTH*REG_ADDR_W-1:0]   entry_rd,
  output logic [DEPTH*XLEN-1:0]         entry_data,
  output logic [DEPTH-1:0]              entry_valid
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [REG_ADDR_W-1:0] rd_q   [DEPTH];
  logic [XLEN-1:0]       data_q [DEPTH];
  logic [DEPTH-1:0]      valid_q;
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         wr_ptr_b;
  logic [CW-1:0]         n_push;

  // b lands in the slot after a when both push in the same cycle
  assign wr_ptr_b = push_a ? wr_ptr + AW'(1) : wr_ptr;
  assign n_push   = CW'(push_a) + CW'(push_b);

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      valid_q <= '0;
    end else begin
      if (pop) begin
        valid_q[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + AW'(1);
      end
      if (push_a) begin
        rd_q[wr_ptr]    <= rd_a;
        data_q[wr_ptr]  <= data_a;
        valid_q[wr_ptr] <= 1'b1;
      end
      if (push_b) begin
        rd_q[wr_ptr_b]    <= rd_b;
        data_q[wr_ptr_b]  <= data_b;
        valid_q[wr_ptr_b] <= 1'b1;
      end
      wr_ptr <= wr_ptr + AW'(n_push);
      count  <= count + n_push - CW'(pop);
    end
  end

  // Flatten slot storage for the parent
  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign entry_rd[i*REG_ADDR_W +: REG_ADDR_W] = rd_q[i];
    assign entry_data[i*XLEN +: XLEN]           = data_q[i];
  end

  assign entry_valid = valid_q;

endmodule

// File: rtl/writeback_unit.sv
// Writeback unit: merges ALU and load results into an in-order queue and
// retires one register-file write per cycle from the head.
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   alu_valid/alu_ready/alu_rd/alu_data   ALU result handshake
//   mem_valid/mem_ready/mem_rd/mem_data   load result handshake
//   reg_write/write_reg/write_data    register-file write port (head entry)
//   fwd_reg/fwd_hit/fwd_data          forwarding lookup (WB_FORWARD_EN only)
//   pending                           per-register "write queued" flags
// Optional feature macro: WB_FORWARD_EN builds the youngest-match
// forwarding lookup and its ports.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            reg_write,
  output logic [4:0]      write_reg,
  output logic [XLEN-1:0] write_data,
`ifdef WB_FORWARD_EN
  input  logic [4:0]      fwd_reg,
  output logic            fwd_hit,
  output logic [XLEN-1:0] fwd_data,
`endif
  output logic [31:0]     pending
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [CW-1:0]               count;
  logic [AW-1:0]               rd_ptr;
  logic [DEPTH*REG_ADDR_W-1:0] entry_rd;
  logic [DEPTH*XLEN-1:0]       entry_data;
  logic [DEPTH-1:0]            entry_valid;
  logic                        alu_take;
  logic                        mem_take;
  logic                        push_a;
  logic                        push_b;
  logic [CW:0]                 mem_level;

  // Ready uses start-of-cycle occupancy; the same-cycle pop is not credited
  assign alu_ready = count < CW'(DEPTH);
  assign alu_take  = alu_valid & alu_ready;
  assign mem_level = {1'b0, count} + (CW+1)'(alu_take);
  assign mem_ready = mem_level < (CW+1)'(DEPTH);
  assign mem_take  = mem_valid & mem_ready;

  // Writes to x0 complete the handshake but are dropped
  assign push_a = alu_take & (alu_rd != 5'd0);
  assign push_b = mem_take & (mem_rd != 5'd0);

  assign reg_write = (count != '0);

  wb_fifo #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_a      (push_a),
    .rd_a        (alu_rd),
    .data_a      (alu_data),
    .push_b      (push_b),
    .rd_b        (mem_rd),
    .data_b      (mem_data),
    .pop         (reg_write),
    .count       (count),
    .rd_ptr      (rd_ptr),
    .entry_rd    (entry_rd),
    .entry_data  (entry_data),
    .entry_valid (entry_valid)
  );

  // Head entry drives the register-file port, zero when empty
  always_comb begin
    write_reg  = '0;
    write_data = '0;
    if (reg_write) begin
      write_reg  = entry_rd[int'(rd_ptr)*REG_ADDR_W +: REG_ADDR_W];
      write_data = entry_data[int'(rd_ptr)*XLEN +: XLEN];
    end
  end

  // Pending scoreboard: OR of valid slots by destination
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) begin
        pending[entry_rd[i*REG_ADDR_W +: REG_ADDR_W]] = 1'b1;
      end
    end
    pending[0] = 1'b0;
  end

`ifdef WB_FORWARD_EN
  logic [AW-1:0] slot;

  // Walk oldest to youngest so the last match (youngest) wins
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    slot     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = rd_ptr + AW'(k);
      if ((fwd_reg != 5'd0) && entry_valid[slot] &&
          (entry_rd[int'(slot)*REG_ADDR_W +: REG_ADDR_W] == fwd_reg)) begin
        fwd_hit  = 1'b1;
        fwd_data = entry_data[int'(slot)*XLEN +: XLEN];
      end
    end
  end
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit with a queue-based expected-write model.
module tb_writeback_unit;
  import wb_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned XLEN  = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            mem_valid;
  logic            mem_ready;
  logic [4:0]      mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            reg_write;
  logic [4:0]      write_reg;
  logic [XLEN-1:0] write_data;
  logic [31:0]     pending;
`ifdef WB_FORWARD_EN
  logic [4:0]      fwd_reg;
  logic            fwd_hit;
  logic [XLEN-1:0] fwd_data;
`endif

  wb_entry_t sbq[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  writeback_unit #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
`ifdef WB_FORWARD_EN
    .fwd_reg    (fwd_reg),
    .fwd_hit    (fwd_hit),
    .fwd_data   (fwd_data),
`endif
    .pending    (pending)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_pending();
    logic [31:0] p = '0;
    foreach (sbq[i]) p[sbq[i].rd] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  // Compare registered-state outputs against the model queue
  task automatic check_outputs();
    logic [4:0]  er = '0;
    logic [31:0] ed = '0;
    if (sbq.size() != 0) begin
      er = sbq[0].rd;
      ed = sbq[0].data;
    end
    chk("reg_write", 32'(reg_write), 32'(sbq.size() != 0));
    chk("write_reg", 32'(write_reg), 32'(er));
    chk("write_data", write_data, ed);
    chk("pending", pending, model_pending());
`ifdef WB_FORWARD_EN
    begin
      logic        eh = 1'b0;
      logic [31:0] efd = '0;
      foreach (sbq[i]) begin
        if (fwd_reg != 5'd0 && sbq[i].rd == fwd_reg) begin
          eh  = 1'b1;
          efd = sbq[i].data;
        end
      end
      chk("fwd_hit", 32'(fwd_hit), 32'(eh));
      chk("fwd_data", fwd_data, efd);
    end
`endif
  endtask

  // One clock: drive at the falling edge, check, then advance the model
  task automatic cycle(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md);
    logic ea;
    logic em;
    alu_valid = av; alu_rd = ar; alu_data = ad;
    mem_valid = mv; mem_rd = mr; mem_data = md;
`ifdef WB_FORWARD_EN
    fwd_reg = 5'($urandom_range(0, 7));
`endif
    #1;
    ea = (sbq.size() < DEPTH);
    em = ((sbq.size() + ((av && ea) ? 1 : 0)) < DEPTH);
    chk("alu_ready", 32'(alu_ready), 32'(ea));
    chk("mem_ready", 32'(mem_ready), 32'(em));
    check_outputs();
    @(posedge clk);
    if (sbq.size() != 0) void'(sbq.pop_front());
    if (av && ea && ar != 5'd0) sbq.push_back('{rd: ar, data: ad});
    if (mv && em && mr != 5'd0) sbq.push_back('{rd: mr, data: md});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  // Reset edge with live handshakes that must be ignored
  task automatic reset_cycle(input logic [4:0] ar, input logic [4:0] mr);
    reset = 1'b1;
    alu_valid = 1'b1; alu_rd = ar; alu_data = 32'h1234_5678;
    mem_valid = 1'b1; mem_rd = mr; mem_data = 32'h8765_4321;
    @(posedge clk);
    sbq.delete();
    @(negedge clk);
    #1;
    chk("rst_alu_ready", 32'(alu_ready), 32'd1);
    chk("rst_mem_ready", 32'(mem_ready), 32'd1);
    check_outputs();
    reset = 1'b0;
    alu_valid = 1'b0;
    mem_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
`ifdef WB_FORWARD_EN
    fwd_reg = '0;
`endif
    @(negedge clk);
    reset_cycle(5'd4, 5'd6);
    reset_cycle(5'd4, 5'd6);
    @(negedge clk);

    // Single ALU write
    cycle(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);
    chk("single_pend5", 32'(pending[5]), 32'd1);
    chk("single_data", write_data, 32'hDEAD_BEEF);
    idle(2);
    chk("single_pend5_clr", 32'(pending[5]), 32'd0);

    // Same-edge ALU and MEM to one register: ALU first
    cycle(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
    chk("dual_first", write_data, 32'h11);
    idle(1);
    chk("dual_second", write_data, 32'h22);
    chk("dual_pend3", 32'(pending[3]), 32'd1);
    idle(1);
    chk("dual_pend3_clr", 32'(pending[3]), 32'd0);
    idle(1);

    // Stream both sources to exercise backpressure
    for (int i = 0; i < 8; i++)
      cycle(1'b1, 5'(1 + i), 32'h100 + 32'(i), 1'b1, 5'(9 + i), 32'h200 + 32'(i));

    // Reset with entries queued, then confirm the next entry is next written
    reset_cycle(5'd7, 5'd8);
    cycle(1'b1, 5'd12, 32'hCAFE, 1'b0, 5'd0, 32'd0);
    chk("post_rst_reg", 32'(write_reg), 32'd12);
    chk("post_rst_data", write_data, 32'hCAFE);
    idle(2);

    // Writes to x0 are accepted and dropped
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55);
    chk("x0_reg_write", 32'(reg_write), 32'd0);
    chk("x0_pending", pending, 32'd0);
    cycle(1'b1, 5'd0, 32'h66, 1'b1, 5'd0, 32'h77);
    chk("x0_both", 32'(reg_write), 32'd0);
    idle(1);

    // Mixed traffic with heavy destination reuse
    for (int i = 0; i < 40; i++)
      cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
    idle(5);

`ifdef WB_FORWARD_EN
    // Youngest-match forwarding
    cycle(1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB);
    fwd_reg = 5'd7;
    #1;
    chk("fwd_hit7", 32'(fwd_hit), 32'd1);
    chk("fwd_data7", fwd_data, 32'hB);
    fwd_reg = 5'd0;
    #1;
    chk("fwd_hit0", 32'(fwd_hit), 32'd0);
    chk("fwd_data0", fwd_data, 32'd0);
    @(negedge clk);
    idle(3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter: DEPTH, 4, write-queue entries; power of two, minimum 2.
REQ-002 Parameter: XLEN, 32, register data width.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: alu_valid / alu_ready  input / output  1 / 1  ALU result handshake.
REQ-006 Port: alu_rd / alu_data  input  5 / XLEN  ALU destination register and value.
REQ-007 Port: mem_valid / mem_ready  input / output  1 / 1  load-result handshake.
REQ-008 Port: mem_rd / mem_data  input  5 / XLEN  load destination register and value.
REQ-009 Port: reg_write / write_reg / write_data  output  1 / 5 / XLEN  drives the register-file write port.
REQ-010 Port: pending  output  32  per-register "write queued" scoreboard.
REQ-011 Port: fwd_reg / fwd_hit / fwd_data  input / output / output  5 / 1 / XLEN  forwarding lookup; present only under WB_FORWARD_EN.

Function
REQ-012 A source transfer SHALL occur on a rising edge where valid and ready are both high.
REQ-013 Accepted entries SHALL go into an in-order FIFO; when both sources transfer in the same cycle, the ALU entry SHALL be ordered ahead of the MEM entry.
REQ-014 alu_ready SHALL be high iff count < DEPTH, using the count at the start of the cycle.
REQ-015 mem_ready SHALL be high iff count + (alu_valid & alu_ready) < DEPTH; a pop in the same cycle SHALL NOT be credited.
REQ-016 Transfers with rd == 0 SHALL be accepted (ready rules unchanged) and discarded, with no enqueue and no pending change.
REQ-017 reg_write SHALL equal (count != 0); write_reg and write_data SHALL show the head entry, and SHALL be 0 when the queue is empty.
REQ-018 The head SHALL be popped on every edge where reg_write is high, giving one register write per cycle.
REQ-019 An entry accepted at edge N SHALL be written at edge N+1 if the queue was empty; otherwise one edge later per entry ahead of it.
REQ-020 Push and pop in the same cycle SHALL both take effect, with count updated by pushes minus pops.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH, and count SHALL range 0..DEPTH.
REQ-022 pending[i] SHALL be high iff any queued entry targets register i; pending[0] SHALL always be 0.
REQ-023 Duplicate destinations in the queue SHALL be allowed; they are written in order, so the youngest value persists.

Reset
REQ-024 While reset is high at an edge, the queue SHALL empty and all handshakes SHALL be ignored.
REQ-025 After reset, and while reset is held: count=0, reg_write=0, write_reg=0, write_data=0, pending=0, fwd_hit=0, fwd_data=0, alu_ready=1, mem_ready=1.
REQ-026 Reset asserted mid-operation SHALL drop all queued entries, and no register write SHALL follow.

Configuration
REQ-027 When macro WB_FORWARD_EN is defined, fwd_hit SHALL be high iff fwd_reg != 0 and a queued entry targets fwd_reg.
REQ-028 Under WB_FORWARD_EN, fwd_data SHALL carry the youngest matching entry, combinationally, and 0 on a miss.
REQ-029 When WB_FORWARD_EN is undefined, the fwd_* ports SHALL be absent and no lookup logic SHALL be built.

Structure
REQ-030 Package wb_pkg SHALL hold REG_ADDR_W=5, the XLEN default, and typedef wb_entry_t {rd, data}.
REQ-031 Storage SHALL be a sub-module wb_fifo with dual push (ordered) and single pop, exposing all entries and their valid bits for the pending and forwarding logic.

Verification
REQ-032 Single write: alu (rd=5, 0xDEADBEEF) at edge 1 -> reg_write=1, write_reg=5, write_data=0xDEADBEEF during the cycle after edge 1; pending[5]=1 over the same span.
REQ-033 Simultaneous sources: alu (3, 0x11) and mem (3, 0x22) at the same edge -> writes 0x11 then 0x22 on consecutive edges; final value 0x22; pending[3] clears after the second write.
REQ-034 Full/backpressure: DEPTH=4, hold the sink busy by streaming both sources -> alu_ready=0 at count=4; mem_ready=0 whenever count + ALU take ≥ 4; no entry lost or reordered.
REQ-035 x0 discard: mem (rd=0, 0x55) -> mem_ready=1, reg_write stays 0, pending stays 0.
REQ-036 Reset mid-stream: 3 entries queued, assert reset one cycle -> reg_write=0, pending=0, alu_ready=1, and the next accepted entry is the next one written.
REQ-037 Forwarding (WB_FORWARD_EN): queue (7, 0xA) then (7, 0xB), fwd_reg=7 -> fwd_hit=1, fwd_data=0xB; fwd_reg=0 -> fwd_hit=0.
